// File: rtl/platform_collision_scanner.sv
// Platform landing detector: scans one platform slot per clock after each
// frame tick and reports whether the falling doodle landed on one.
module platform_collision_scanner #(
  parameter int FPS         = 60,
  parameter int CLK         = 50000000,
  parameter int N_PLATFORMS = 90,
  parameter int PLAT_W      = 100,
  parameter int PLAT_H      = 30,
  parameter int DOODLE_W    = 80,
  parameter int DOODLE_H    = 80,
  parameter int FOOT_TOL    = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(CLK/FPS):0]   fps_counter,
  input  logic [10:0]                doodle_x,
  input  logic [9:0]                 doodle_y,
  input  logic                       doodle_falling,
  input  logic signed [10:0]         platforms [0:N_PLATFORMS-1][0:1],
  input  logic [N_PLATFORMS-1:0]     platform_activation,
  output logic                       move_collision,
  output logic                       collision_pulse,
  output logic [6:0]                 hit_index,
  output logic signed [10:0]         hit_y,
  output logic                       scan_busy,
  output logic                       frame_overrun
);

  if (CLK / FPS < N_PLATFORMS + 4) begin : g_rate_chk
    $error("frame period too short for a full platform scan");
  end
  if (N_PLATFORMS > 128 || N_PLATFORMS < 1) begin : g_np_chk
    $error("N_PLATFORMS must fit the 7-bit hit index");
  end
  if (FOOT_TOL > PLAT_H) begin : g_tol_chk
    $error("landing band deeper than the platform itself");
  end

  localparam logic signed [11:0] DW1 = 12'(DOODLE_W - 1);
  localparam logic signed [11:0] PW1 = 12'(PLAT_W - 1);
  localparam logic signed [11:0] DH  = 12'(DOODLE_H);
  localparam logic signed [11:0] FT1 = 12'(FOOT_TOL - 1);
  localparam logic [6:0]         LAST_IDX = 7'(N_PLATFORMS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state;
  logic [6:0]         idx;
  logic [10:0]        snap_x;
  logic [9:0]         snap_y;
  logic               snap_fall;
  logic               hit_found;
  logic [6:0]         hit_idx_r;
  logic signed [10:0] hit_y_r;

  logic               tick;
  logic               start;
  logic               last;
  logic               cur_hit;
  logic signed [11:0] px;
  logic signed [11:0] py;
  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic signed [11:0] feet;

  assign tick  = &fps_counter;
  assign start = tick && (state != SCAN);
  assign last  = (idx == LAST_IDX);

  // Landing test of the slot under the scan pointer against the snapshot.
  always_comb begin
    px   = {platforms[idx][1][10], platforms[idx][1]};
    py   = {platforms[idx][0][10], platforms[idx][0]};
    dx   = {1'b0, snap_x};
    dy   = {2'b00, snap_y};
    feet = dy + DH;
    cur_hit = platform_activation[idx] && snap_fall
           && (dx + DW1 >= px) && (dx <= px + PW1)
           && (feet >= py) && (feet <= py + FT1);
  end

  // Scan sequencer with registered results; first hit in a scan wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      snap_x          <= '0;
      snap_y          <= '0;
      snap_fall       <= 1'b0;
      hit_found       <= 1'b0;
      hit_idx_r       <= '0;
      hit_y_r         <= '0;
      move_collision  <= 1'b0;
      collision_pulse <= 1'b0;
      hit_index       <= '0;
      hit_y           <= '0;
      scan_busy       <= 1'b0;
      frame_overrun   <= 1'b0;
    end else begin
      collision_pulse <= 1'b0;
      unique case (state)
        IDLE: ;
        SCAN: begin
          if (tick) frame_overrun <= 1'b1;
          if (cur_hit && !hit_found) begin
            hit_found <= 1'b1;
            hit_idx_r <= idx;
            hit_y_r   <= platforms[idx][0];
          end
          if (last) begin
            state           <= DONE;
            scan_busy       <= 1'b0;
            collision_pulse <= hit_found | cur_hit;
          end else begin
            idx <= idx + 7'd1;
          end
        end
        DONE: begin
          move_collision <= hit_found;
          if (hit_found) begin
            hit_index <= hit_idx_r;
            hit_y     <= hit_y_r;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (start) begin
        state     <= SCAN;
        scan_busy <= 1'b1;
        idx       <= '0;
        hit_found <= 1'b0;
        snap_x    <= doodle_x;
        snap_y    <= doodle_y;
        snap_fall <= doodle_falling;
      end
    end
  end

endmodule

// File: tb/tb_platform_collision_scanner.sv
// Bench for platform_collision_scanner: directed edge cases plus
// randomized frames checked against a slot-by-slot landing model.
module tb_platform_collision_scanner;

  localparam int NP = 90;

  logic               clk;
  logic               rst;
  logic [7:0]         fps_counter;
  logic [10:0]        doodle_x;
  logic [9:0]         doodle_y;
  logic               doodle_falling;
  logic signed [10:0] platforms [0:NP-1][0:1];
  logic [NP-1:0]      platform_activation;
  logic               move_collision;
  logic               collision_pulse;
  logic [6:0]         hit_index;
  logic signed [10:0] hit_y;
  logic               scan_busy;
  logic               frame_overrun;

  int checks = 0;
  int errors = 0;

  logic               m_col;
  int                 m_idx;
  logic signed [10:0] m_y;
  logic               m_ovr;

  platform_collision_scanner #(
    .FPS(10), .CLK(1000), .N_PLATFORMS(NP)
  ) dut (
    .clk(clk), .rst(rst), .fps_counter(fps_counter),
    .doodle_x(doodle_x), .doodle_y(doodle_y),
    .doodle_falling(doodle_falling), .platforms(platforms),
    .platform_activation(platform_activation),
    .move_collision(move_collision),
    .collision_pulse(collision_pulse), .hit_index(hit_index),
    .hit_y(hit_y), .scan_busy(scan_busy),
    .frame_overrun(frame_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Lowest active slot whose landing band contains the doodle's feet.
  function automatic int model_hit();
    int dx, dy, feet, px, py;
    dx = int'(doodle_x);
    dy = int'(doodle_y);
    feet = dy + 80;
    for (int i = 0; i < NP; i++) begin
      px = int'(platforms[i][1]);
      py = int'(platforms[i][0]);
      if (platform_activation[i] && doodle_falling
          && dx + 79 >= px && dx <= px + 99
          && feet >= py && feet <= py + 11)
        return i;
    end
    return -1;
  endfunction

  task automatic clear_plats();
    platform_activation = '0;
    for (int i = 0; i < NP; i++) begin
      platforms[i][0] = 11'($urandom);
      platforms[i][1] = 11'($urandom);
    end
  endtask

  task automatic place(input int i, input int y, input int x);
    platforms[i][0] = 11'(y);
    platforms[i][1] = 11'(x);
    platform_activation[i] = 1'b1;
  endtask

  task automatic set_doodle(input int x, input int y, input bit f);
    doodle_x = 11'(x);
    doodle_y = 10'(y);
    doodle_falling = f;
  endtask

  // One full frame; extra > 0 injects a second tick at T+extra.
  task automatic frame(input string nm, input int extra);
    int e;
    e = model_hit();
    @(posedge clk); #1 fps_counter = '1;
    @(posedge clk); #1 fps_counter = '0;
    check({nm, ":busy_t1"}, 32'(scan_busy), 32'd1);
    check({nm, ":held_col"}, 32'(move_collision), 32'(m_col));
    check({nm, ":held_idx"}, 32'(hit_index), 32'(m_idx));
    for (int k = 1; k < 90; k++) begin
      fps_counter = (k == extra) ? 8'hFF : 8'h00;
      @(posedge clk); #1;
    end
    fps_counter = '0;
    if (extra > 0) m_ovr = 1'b1;
    check({nm, ":pulse_t90"}, 32'(collision_pulse), 32'd0);
    check({nm, ":busy_t90"}, 32'(scan_busy), 32'd1);
    @(posedge clk); #1;
    check({nm, ":pulse_t91"}, 32'(collision_pulse), 32'(e >= 0));
    check({nm, ":busy_t91"}, 32'(scan_busy), 32'd0);
    m_col = (e >= 0);
    if (e >= 0) begin
      m_idx = e;
      m_y = platforms[e][0];
    end
    @(posedge clk); #1;
    check({nm, ":col"}, 32'(move_collision), 32'(m_col));
    check({nm, ":idx"}, 32'(hit_index), 32'(m_idx));
    check({nm, ":y"}, 32'(hit_y), 32'(m_y));
    check({nm, ":pulse_t92"}, 32'(collision_pulse), 32'd0);
    check({nm, ":ovr"}, 32'(frame_overrun), 32'(m_ovr));
  endtask

  task automatic reset_outputs(input string nm);
    check({nm, ":col"}, 32'(move_collision), 32'd0);
    check({nm, ":pulse"}, 32'(collision_pulse), 32'd0);
    check({nm, ":idx"}, 32'(hit_index), 32'd0);
    check({nm, ":y"}, 32'(hit_y), 32'd0);
    check({nm, ":busy"}, 32'(scan_busy), 32'd0);
    check({nm, ":ovr"}, 32'(frame_overrun), 32'd0);
    m_col = 1'b0;
    m_idx = 0;
    m_y = '0;
    m_ovr = 1'b0;
  endtask

  initial begin
    int pulses;
    int yv [3];
    rst = 1'b1;
    fps_counter = '0;
    set_doodle(0, 0, 1'b0);
    clear_plats();
    repeat (3) @(posedge clk);
    #1 reset_outputs("reset");
    rst = 1'b0;

    place(5, 400, 400);
    set_doodle(420, 320, 1'b1);
    frame("basic", 0);
    set_doodle(420, 320, 1'b0);
    frame("rising", 0);
    set_doodle(420, 320, 1'b1);
    platform_activation[5] = 1'b0;
    frame("inactive", 0);
    platform_activation[5] = 1'b1;

    set_doodle(420, 331, 1'b1); frame("dy331", 0);
    set_doodle(420, 332, 1'b1); frame("dy332", 0);
    set_doodle(420, 319, 1'b1); frame("dy319", 0);
    set_doodle(321, 320, 1'b1); frame("dx321", 0);
    set_doodle(320, 320, 1'b1); frame("dx320", 0);
    set_doodle(499, 320, 1'b1); frame("dx499", 0);
    set_doodle(500, 320, 1'b1); frame("dx500", 0);

    place(3, 400, 400);
    place(7, 400, 400);
    set_doodle(420, 320, 1'b1);
    frame("lowest", 0);

    clear_plats();
    place(0, -162, 400);
    yv[0] = 0;
    yv[1] = 1023;
    yv[2] = int'($urandom_range(0, 1023));
    foreach (yv[j]) begin
      set_doodle(420, yv[j], 1'b1);
      frame("negy", 0);
    end

    clear_plats();
    place(5, 400, 400);
    set_doodle(420, 320, 1'b1);
    frame("overrun", 10);

    clear_plats();
    place(9, 500, 200);
    set_doodle(250, 420, 1'b1);
    @(posedge clk); #1 fps_counter = '1;
    @(posedge clk); #1 fps_counter = '0;
    repeat (39) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    reset_outputs("midrst");
    pulses = 0;
    repeat (54) begin
      @(posedge clk); #1;
      if (collision_pulse) pulses++;
    end
    check("midrst:nopulse", 32'(pulses), 32'd0);
    frame("after_rst", 0);

    for (int r = 0; r < 8; r++) begin
      clear_plats();
      set_doodle(int'($urandom_range(300, 520)),
                 int'($urandom_range(300, 340)),
                 ($urandom_range(0, 3) != 0));
      for (int s = 0; s < 4; s++)
        place(int'($urandom_range(0, NP - 1)),
              int'($urandom_range(390, 425)),
              int'($urandom_range(250, 550)));
      frame("rand", 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/platform_collision_scanner.md
Name: platform_collision_scanner

Overview:
Consumer side of the platform field: reads the platform position/activation arrays from the platform manager and the doodle position, and decides once per frame whether the falling doodle has landed on an active platform. Checks one platform per clock after each frame tick, then drives the move_collision level back to the platform manager and the doodle physics. Also reports which platform was hit and the snap height for the doodle's feet.

Parameters:
FPS, 60, frame rate; frame tick is fps_counter all-ones
CLK, 50000000, clock frequency in Hz; CLK/FPS must be >= N_PLATFORMS+4 (elaboration assertion)
N_PLATFORMS, 90, number of platform slots scanned
PLAT_W, 100, platform width in pixels
PLAT_H, 30, platform height in pixels (informational; landing band uses FOOT_TOL)
DOODLE_W, 80, doodle sprite width in pixels
DOODLE_H, 80, doodle sprite height in pixels
FOOT_TOL, 12, landing band depth in pixels below platform top (equals per-frame scroll step)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
fps_counter  in  $clog2(CLK/FPS)+1  frame counter; all-ones = frame tick
doodle_x  in  11  doodle left edge, unsigned
doodle_y  in  10  doodle top edge, unsigned
doodle_falling  in  1  1 = doodle vertical velocity downward
platforms  in  N_PLATFORMS x 2 x 11 signed  [i][0]=top y, [i][1]=left x
platform_activation  in  N_PLATFORMS  1 = slot i is active
move_collision  out  1  landing detected in the last completed scan; held level
collision_pulse  out  1  one-cycle strobe at scan completion when a hit is found
hit_index  out  7  lowest index hit in the last completed scan
hit_y  out  11 signed  platform top y of hit_index (feet snap target)
scan_busy  out  1  high while SCAN is active
frame_overrun  out  1  sticky; set when a tick arrives during SCAN

Behaviour:
- Reset values: move_collision=0, collision_pulse=0, hit_index=0, hit_y=0, scan_busy=0, frame_overrun=0; FSM=IDLE; idx=0.
- FSM states: IDLE, SCAN, DONE.
- IDLE: on the tick (cycle T), the doodle position and doodle_falling are captured into a snapshot register, and the FSM goes to SCAN with idx=0 and hit_found=0.
- SCAN: idx i is evaluated in cycle T+1+i, with platforms/platform_activation sampled live. These arrays are stable during the scan because the manager only updates them on the tick edge.
- SCAN ends after idx=N_PLATFORMS-1, then the FSM goes to DONE.
- DONE, cycle T+N_PLATFORMS+1:
  - move_collision<=hit_found.
  - If hit_found: hit_index and hit_y are loaded, and collision_pulse is high for exactly this cycle.
  - If no hit: hit_index and hit_y hold their previous values.
  - The FSM then returns to IDLE.
- Outputs are visible from cycle T+N_PLATFORMS+2 and are held until the next DONE. The manager therefore samples a stable value at the following tick.
- scan_busy=1 exactly while the FSM is in SCAN.
- Hit condition for slot i, all arithmetic signed 12-bit with operands sign-extended:
  - act[i] and snapshot doodle_falling;
  - dx+DOODLE_W-1 >= px and dx <= px+PLAT_W-1;
  - feet = dy+DOODLE_H, with py <= feet <= py+FOOT_TOL-1.
- Negative py (offscreen top) is valid and is compared signed. A platform with py in -162..-1 can never match, because feet >= DOODLE_H.
- Multiple hits: the lowest index wins. The first hit latches and later hits are ignored.
- Tick during SCAN: it is ignored, the scan continues and frame_overrun is set (sticky until rst). Unreachable when the parameter assertion holds.
- Tick during DONE: the DONE actions complete, and the tick is taken as a new start (the FSM goes to SCAN).
- Reset mid-scan: everything returns to reset values within one cycle and no pulse is emitted. The next tick scans normally.

Test Plan:
Bench uses CLK=1000, FPS=10 (tick every 100 cycles); all slots inactive unless stated.
- Slot 5 active at y=400, x=400; doodle x=420, y=320, falling -> collision_pulse at T+91; move_collision=1, hit_index=5, hit_y=400 from T+92, held through the next tick.
- Same as above with doodle_falling=0 -> move_collision=0, no pulse, hit_index holds its old value.
- Same as above with platform_activation[5]=0 -> no hit.
- Vertical edges with slot 5 at y=400: dy=320 (feet 400) hit, dy=331 (feet 411) hit, dy=332 (feet 412) miss, dy=319 (feet 399) miss.
- Horizontal edges with slot 5 at x=400: dx=321 hit, dx=320 miss, dx=499 hit, dx=500 miss.
- Slots 3 and 7 active, both at y=400, x=400, doodle positioned to hit -> hit_index=3.
- Slot 0 at y=-162 -> no hit for any doodle_y.
- Assert rst at T+40 with a pending hit -> all outputs 0, no pulse; the next tick yields a correct hit at T'+91.
